mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4-bit mux_4to1-style datapath among four requesters.

---
 rtl/mux4_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 operand mux among four sources,
// with a registered valid/ready output stage; MUX_ARB_LOCK_EN adds burst lock.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
`ifdef MUX_ARB_LOCK_EN
    input  logic [3:0]       lock,
`endif
    output logic [3:0]       ack,
    output logic [3:0]       grant,
    output logic [1:0]       select,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] beat_cnt;

    logic [1:0]       owner;
    logic [1:0]       nxt_start;
    logic [WIDTH-1:0] sel_data;
    logic             req_own;
    logic             load;
    logic             locked;
    logic             limit_hit;
    logic [3:0]       own_oh;
    logic [3:0]       others;
    logic [1:0]       idle_pick;
    logic [1:0]       next_pick;
    logic [CW:0]      cnt_inc;

    // First set bit of r scanning start, start+1, ... (mod 4)
    function automatic logic [1:0] rr_pick(
        input logic [3:0] r,
        input logic [1:0] start
    );
        logic [1:0] idx;
        rr_pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    // Operand mux driven by the registered owner
    always_comb begin
        sel_data = in0;
        unique case (select)
            2'd0: sel_data = in0;
            2'd1: sel_data = in1;
            2'd2: sel_data = in2;
            2'd3: sel_data = in3;
            default: sel_data = in0;
        endcase
    end

    // Load / burst-limit / next-owner decisions for the current cycle
    always_comb begin
        owner     = select;
        own_oh    = 4'b0001 << owner;
        nxt_start = owner + 2'd1;
        req_own   = req[owner];
        load      = (state == GRANT) & req_own & (~out_valid | out_ready);
        ack       = load ? own_oh : 4'b0000;
        others    = req & ~own_oh;
        cnt_inc   = {1'b0, beat_cnt} + 1'b1;
        limit_hit = cnt_inc >= (CW+1)'(MAX_BURST);
`ifdef MUX_ARB_LOCK_EN
        locked    = lock[owner];
`else
        locked    = 1'b0;
`endif
        idle_pick = rr_pick(req, ptr);
        next_pick = rr_pick(others, nxt_start);
    end

    assign busy = (state == GRANT);

    // Ownership FSM: grant, select, rotation pointer and burst counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= 4'b0000;
            select   <= 2'd0;
            ptr      <= 2'd0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        grant    <= 4'b0001 << idle_pick;
                        select   <= idle_pick;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req_own) begin
                        ptr      <= nxt_start;
                        beat_cnt <= '0;
                        if (|req) begin
                            grant  <= 4'b0001 << next_pick;
                            select <= next_pick;
                        end else begin
                            state <= IDLE;
                            grant <= 4'b0000;
                        end
                    end else if (load) begin
                        if (limit_hit && !locked) begin
                            beat_cnt <= '0;
                            if (|others) begin
                                ptr    <= nxt_start;
                                grant  <= 4'b0001 << next_pick;
                                select <= next_pick;
                            end
                        end else if (limit_hit) begin
                            beat_cnt <= CW'(MAX_BURST);
                        end else begin
                            beat_cnt <= cnt_inc[CW-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered output stage with valid/ready handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed testbench for mux4_rr_arbiter (WIDTH=4, MAX_BURST=4).
// Lock scenario is included when MUX_ARB_LOCK_EN is defined.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] in0 = 4'h0;
    logic [3:0] in1 = 4'h0;
    logic [3:0] in2 = 4'h0;
    logic [3:0] in3 = 4'h0;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0] lock = 4'b0;
`endif
    logic [3:0] ack;
    logic [3:0] grant;
    logic [1:0] select;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       busy;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
`ifdef MUX_ARB_LOCK_EN
        .lock(lock),
`endif
        .ack(ack),
        .grant(grant),
        .select(select),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        tick();
        tick();
        checks++;
        if (grant !== 4'b0) begin
            errors++;
            $display("FAIL reset_grant got %b exp 0000", grant);
        end
        checks++;
        if (select !== 2'd0) begin
            errors++;
            $display("FAIL reset_select got %0d exp 0", select);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_out got v=%b d=%h exp v=0 d=0",
                     out_valid, out_data);
        end
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL reset_busy_ack got %b %b exp 0 0000", busy, ack);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || grant !== 4'b0) begin
            errors++;
            $display("FAIL idle_noreq got busy=%b grant=%b exp 0 0000",
                     busy, grant);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in2 = 4'hA;
        req = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100 || select !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got %b/%0d/%b exp 0100/2/1",
                     grant, select, busy);
        end
        checks++;
        if (ack !== 4'b0100 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack=%b v=%b exp 0100 0",
                     ack, out_valid);
        end
        tick();
        checks++;
        if (out_data !== 4'hA || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_data got %h v=%b exp a 1",
                     out_data, out_valid);
        end
        req = 4'b0;
        tick();
        checks++;
        if (grant !== 4'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release got %b %b %b exp 0000 0 0",
                     grant, busy, out_valid);
        end
        checks++;
        if (select !== 2'd2) begin
            errors++;
            $display("FAIL single_select_hold got %0d exp 2", select);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_o;
        do_reset();
        in0 = 4'h1;
        in1 = 4'h2;
        in2 = 4'h3;
        in3 = 4'h4;
        out_ready = 1'b1;
        req = 4'b1111;
        tick();
        for (int k = 0; k < 20; k++) begin
            exp_o = 2'((k / 4) % 4);
            checks++;
            if (select !== exp_o || ack !== (4'b0001 << exp_o)) begin
                errors++;
                $display("FAIL fair_owner k=%0d got sel=%0d ack=%b exp %0d",
                         k, select, ack, exp_o);
            end
            tick();
            checks++;
            if (out_data !== 4'(exp_o + 2'd1) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL fair_data k=%0d got %h v=%b exp %h",
                         k, out_data, out_valid, exp_o + 1);
            end
        end
        req = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        in1 = 4'h5;
        out_ready = 1'b1;
        req = 4'b0010;
        tick();
        tick();
        checks++;
        if (out_data !== 4'h5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_first got %h %b exp 5 1", out_data, out_valid);
        end
        in1 = 4'h6;
        out_ready = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b0) begin
            errors++;
            $display("FAIL stall_ack got %b exp 0000", ack);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_data !== 4'h5 || out_valid !== 1'b1 || ack !== 4'b0 ||
                grant !== 4'b0010 || dut.beat_cnt !== 3'd1) begin
                errors++;
                $display("FAIL stall_hold k=%0d got d=%h v=%b a=%b g=%b c=%0d",
                         k, out_data, out_valid, ack, grant, dut.beat_cnt);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0010) begin
            errors++;
            $display("FAIL stall_resume_ack got %b exp 0010", ack);
        end
        tick();
        checks++;
        if (out_data !== 4'h6 || dut.beat_cnt !== 3'd2) begin
            errors++;
            $display("FAIL stall_resume got d=%h c=%0d exp 6 2",
                     out_data, dut.beat_cnt);
        end
        tick();
        tick();
        checks++;
        if (dut.beat_cnt !== 3'd0 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL stall_limit_solo got c=%0d g=%b exp 0 0010",
                     dut.beat_cnt, grant);
        end
        req = 4'b0;
        tick();
        tick();
    endtask

    task automatic test_release();
        do_reset();
        in3 = 4'h9;
        in0 = 4'h7;
        out_ready = 1'b1;
        req = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL rel_first got %b exp 1000", grant);
        end
        tick();
        tick();
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || select !== 2'd0 || dut.ptr !== 2'd0) begin
            errors++;
            $display("FAIL rel_wrap got g=%b s=%0d p=%0d exp 0001 0 0",
                     grant, select, dut.ptr);
        end
        checks++;
        if (out_data !== 4'h9 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rel_drain got %h %b exp 9 0", out_data, out_valid);
        end
        tick();
        tick();
        checks++;
        if (out_data !== 4'h7 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rel_newdata got %h %b exp 7 1", out_data, out_valid);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0 || select !== 2'd0 || out_valid !== 1'b0 ||
            out_data !== 4'h0 || busy !== 1'b0 || ack !== 4'b0) begin
            errors++;
            $display("FAIL rel_midreset got g=%b s=%0d v=%b d=%h b=%b a=%b",
                     grant, select, out_valid, out_data, busy, ack);
        end
        rst_n = 1'b1;
        req = 4'b0;
        tick();
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        out_ready = 1'b1;
        lock = 4'b0001;
        req = 4'b0011;
        tick();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (select !== 2'd0 || ack !== 4'b0001) begin
                errors++;
                $display("FAIL lock_hold k=%0d got s=%0d a=%b exp 0 0001",
                         k, select, ack);
            end
            tick();
        end
        checks++;
        if (dut.beat_cnt !== 3'd4) begin
            errors++;
            $display("FAIL lock_sat got %0d exp 4", dut.beat_cnt);
        end
        lock = 4'b0;
        tick();
        checks++;
        if (select !== 2'd1 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL lock_rotate got s=%0d g=%b exp 1 0010",
                     select, grant);
        end
        req = 4'b0;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_release();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
